// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO read side: Gray/binary pointer
// conversion helpers and the output buffer depth.
package async_fifo_pkg;

  localparam int unsigned RD_BUF_DEPTH = 2;

  // Binary to reflected Gray code; callers cast to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Reflected Gray code to binary; each bit is the XOR of all higher Gray bits.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer for the FIFO read stream. Entry 0 is always the
// oldest word, so dout stays stable while no pop occurs.
module fifo_rd_skid #(
  parameter int DATASIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [DATASIZE-1:0] din,
  input  logic                pop,
  output logic [DATASIZE-1:0] dout,
  output logic [1:0]          count
);

  logic [DATASIZE-1:0] ent0;
  logic [DATASIZE-1:0] ent1;
  logic [1:0]          wr_idx;

  // A push lands behind whatever survives this cycle's pop.
  assign wr_idx = count - {1'b0, pop};
  assign dout   = ent0;

  // Shift on pop, then place the pushed word at the first free slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= '0;
    end else begin
      if (pop) ent0 <= ent1;
      if (push) begin
        if (wr_idx == 2'd0) ent0 <= din;
        else                ent1 <= din;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read side of an asynchronous FIFO presented as a valid/ready stream.
// Prefetches from a registered memory port into a 2-entry output buffer.
// Optional: define RD_LEVEL_EN to add the registered rlevel occupancy output.
module fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE-1:0] mem_raddr,
  output logic                mem_rinc,
  input  logic [DATASIZE-1:0] mem_rdata,
`ifdef RD_LEVEL_EN
  output logic [ADDRSIZE:0]   rlevel,
`endif
  output logic                rempty,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATASIZE-1:0] rdata
);

  localparam int PW = ADDRSIZE + 1;

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbin_next;
  logic [ADDRSIZE:0] rgray_next;
  logic              inflight;
  logic              pop;
  logic [1:0]        count;
  logic [2:0]        occ;

  assign pop = rvalid & rready;

  // Words held or on their way after this cycle's pop; never exceeds the buffer.
  assign occ      = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign mem_rinc = !rempty && (occ < 3'(RD_BUF_DEPTH));

  assign rbin_next  = rbin + {{ADDRSIZE{1'b0}}, mem_rinc};
  assign rgray_next = PW'(bin2gray(32'(rbin_next)));
  assign mem_raddr  = rbin[ADDRSIZE-1:0];
  assign rvalid     = (count != 2'd0);

  // Read pointer, empty flag and in-flight tracking for the registered memory.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin     <= '0;
      rptr     <= '0;
      rempty   <= 1'b1;
      inflight <= 1'b0;
    end else begin
      rbin     <= rbin_next;
      rptr     <= rgray_next;
      rempty   <= (rgray_next == rq2_wptr);
      inflight <= mem_rinc;
    end
  end

`ifdef RD_LEVEL_EN
  // Occupancy seen from the read domain, modulo the pointer range.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) rlevel <= '0;
    else      rlevel <= PW'(gray2bin(32'(rq2_wptr))) - rbin;
  end
`endif

  fifo_rd_skid #(
    .DATASIZE(DATASIZE)
  ) u_skid (
    .clk  (rclk),
    .rst  (rrst),
    .push (inflight),
    .din  (mem_rdata),
    .pop  (pop),
    .dout (rdata),
    .count(count)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream with a registered memory model
// preloaded with mem[i] = 0xA0 + i and a scoreboard queue of expected words.
module tb_fifo_rd_stream;

  logic       rclk;
  logic       rrst;
  logic [4:0] rq2_wptr;
  logic [4:0] rptr;
  logic [3:0] mem_raddr;
  logic       mem_rinc;
  logic [7:0] mem_rdata;
  logic       rempty;
  logic       rvalid;
  logic       rready;
  logic [7:0] rdata;
`ifdef RD_LEVEL_EN
  logic [4:0] rlevel;
`endif

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  fifo_rd_stream #(
    .DATASIZE(8),
    .ADDRSIZE(4)
  ) dut (
    .rclk     (rclk),
    .rrst     (rrst),
    .rq2_wptr (rq2_wptr),
    .rptr     (rptr),
    .mem_raddr(mem_raddr),
    .mem_rinc (mem_rinc),
    .mem_rdata(mem_rdata),
`ifdef RD_LEVEL_EN
    .rlevel   (rlevel),
`endif
    .rempty   (rempty),
    .rvalid   (rvalid),
    .rready   (rready),
    .rdata    (rdata)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
    mem_rdata = 8'h00;
  end

  // Registered memory read port: data one cycle after mem_rinc.
  always @(posedge rclk) begin
    if (mem_rinc) mem_rdata <= mem[mem_raddr];
  end

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = 5'(b % 32);
    return v ^ (v >> 1);
  endfunction

  task automatic do_reset();
    rrst = 1'b1;
    rq2_wptr = 5'd0;
    rready = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge rclk);
    rrst = 1'b0;
  endtask

  task automatic test_reset();
    rrst = 1'b0;
    rq2_wptr = 5'd0;
    rready = 1'b0;
    #1 rrst = 1'b1;
    #1;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL reset_rempty: got %b expected 1", rempty); end
    total++; if (rptr !== 5'h00) begin bad++; $display("FAIL reset_rptr: got %h expected 00", rptr); end
    total++; if (mem_rinc !== 1'b0) begin bad++; $display("FAIL reset_mem_rinc: got %b expected 0", mem_rinc); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
    @(negedge rclk);
    rrst = 1'b0;
  endtask

  task automatic test_stream();
    int npop, first_pop, last_pop;
    logic [7:0] e;
    do_reset();
    @(negedge rclk);
    rq2_wptr = gray5(3);
    rready = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(8'hA0 + i));
    npop = 0; first_pop = -1; last_pop = -1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge rclk); #1;
      if (cyc == 2) begin
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL stream_early_valid: got %b expected 0", rvalid); end
      end
      if (cyc == 3) begin
        total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL stream_latency: got %b expected 1", rvalid); end
      end
      if (rvalid && rready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (rdata !== e) begin bad++; $display("FAIL stream_data: got %h expected %h", rdata, e); end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        npop++;
      end
    end
    total++; if (npop !== 3) begin bad++; $display("FAIL stream_count: got %0d expected 3", npop); end
    total++; if (last_pop - first_pop !== 2) begin bad++; $display("FAIL stream_throughput: got span %0d expected 2", last_pop - first_pop); end
    total++; if (rptr !== 5'h02) begin bad++; $display("FAIL stream_rptr: got %h expected 02", rptr); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL stream_rempty: got %b expected 1", rempty); end
  endtask

  task automatic test_backpressure();
    int nrinc, npop;
    logic [7:0] e;
    do_reset();
    @(negedge rclk);
    rq2_wptr = gray5(4);
    rready = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'hA0 + i));
    nrinc = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge rclk); #1;
      if (mem_rinc) nrinc++;
      if (rvalid) begin
        total++; if (rdata !== 8'hA0) begin bad++; $display("FAIL bp_hold: got %h expected a0", rdata); end
      end
    end
    total++; if (nrinc !== 2) begin bad++; $display("FAIL bp_prefetch: got %0d reads expected 2", nrinc); end
    npop = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge rclk);
      rready = 1'b1;
      #1;
      if (rvalid && rready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (rdata !== e) begin bad++; $display("FAIL bp_data: got %h expected %h", rdata, e); end
        npop++;
      end
    end
    total++; if (npop !== 4) begin bad++; $display("FAIL bp_count: got %0d expected 4", npop); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL bp_rempty: got %b expected 1", rempty); end
  endtask

  task automatic test_wrap();
    int npop, wbin, target;
    logic [4:0] prev;
    logic wrapped;
    logic [7:0] e;
    do_reset();
    rready = 1'b1;
    npop = 0; wbin = 0; wrapped = 1'b0; prev = 5'h00;
    for (int cyc = 0; cyc < 200 && npop < 40; cyc++) begin
      @(negedge rclk);
      target = (npop + 16 < 40) ? npop + 16 : 40;
      while (wbin < target) begin
        exp_q.push_back(8'(8'hA0 + (wbin % 16)));
        wbin++;
      end
      rq2_wptr = gray5(wbin);
      #1;
      if (prev == 5'h10 && rptr == 5'h00) wrapped = 1'b1;
      prev = rptr;
      if (rvalid && rready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (rdata !== e) begin bad++; $display("FAIL wrap_data: got %h expected %h", rdata, e); end
        npop++;
      end
    end
    total++; if (npop !== 40) begin bad++; $display("FAIL wrap_count: got %0d expected 40", npop); end
    repeat (3) @(negedge rclk);
    #1;
    total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL wrap_rptr_wrap: got %b expected 1", wrapped); end
    total++; if (rptr !== 5'h0C) begin bad++; $display("FAIL wrap_rptr_final: got %h expected 0c", rptr); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL wrap_rempty: got %b expected 1", rempty); end
  endtask

  task automatic test_full();
    int npop;
    logic [7:0] e;
    do_reset();
    @(negedge rclk);
    rq2_wptr = 5'h18;
    rready = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'hA0 + i));
    npop = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge rclk); #1;
      if (rvalid && rready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
        total++; if (rdata !== e) begin bad++; $display("FAIL full_data: got %h expected %h", rdata, e); end
        npop++;
      end
    end
    total++; if (npop !== 16) begin bad++; $display("FAIL full_count: got %0d expected 16", npop); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL full_rempty: got %b expected 1", rempty); end
    total++; if (rptr !== 5'h18) begin bad++; $display("FAIL full_rptr: got %h expected 18", rptr); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL full_rvalid: got %b expected 0", rvalid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge rclk);
    rq2_wptr = gray5(4);
    rready = 1'b0;
    repeat (6) @(negedge rclk);
    #1;
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b expected 1", rvalid); end
    #1;
    rrst = 1'b1;
    rq2_wptr = 5'd0;
    exp_q.delete();
    #1;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL mid_rvalid: got %b expected 0", rvalid); end
    total++; if (mem_rinc !== 1'b0) begin bad++; $display("FAIL mid_mem_rinc: got %b expected 0", mem_rinc); end
    total++; if (rempty !== 1'b1) begin bad++; $display("FAIL mid_rempty: got %b expected 1", rempty); end
    total++; if (rptr !== 5'h00) begin bad++; $display("FAIL mid_rptr: got %h expected 00", rptr); end
    @(negedge rclk);
    rrst = 1'b0;
    rready = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge rclk); #1;
      total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL mid_post_rvalid: got %b expected 0 at cycle %0d", rvalid, cyc); end
      total++; if (mem_rinc !== 1'b0) begin bad++; $display("FAIL mid_post_rinc: got %b expected 0 at cycle %0d", mem_rinc, cyc); end
    end
  endtask

`ifdef RD_LEVEL_EN
  task automatic test_level();
    logic [4:0] exp_lvl [5];
    exp_lvl[0] = 5'd5; exp_lvl[1] = 5'd5; exp_lvl[2] = 5'd4;
    exp_lvl[3] = 5'd3; exp_lvl[4] = 5'd3;
    do_reset();
    @(negedge rclk);
    rq2_wptr = gray5(5);
    rready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge rclk); #1;
      total++; if (rlevel !== exp_lvl[cyc]) begin bad++; $display("FAIL level_%0d: got %0d expected %0d", cyc, rlevel, exp_lvl[cyc]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_full();
    test_reset_mid();
`ifdef RD_LEVEL_EN
    test_level();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
